// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the P7 pipeline datapath (master) and the
// stall/flush scheduler (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic             use_rs_D;
  logic             use_rt_D;
  logic [1:0]       Tuse_rs_D;
  logic [1:0]       Tuse_rt_D;
  logic             RegWrite_E;
  logic [4:0]       Dst_E;
  logic [1:0]       Tnew_E;
  logic             RegWrite_M;
  logic [4:0]       Dst_M;
  logic [1:0]       Tnew_M;
  logic             md_use_D;
  logic             md_start_E;
  logic             md_div_E;
  logic             eret_D;
  logic             mtc0_epc_E;
  logic             mtc0_epc_M;
  logic             Req;
  logic             stall_F;
  logic             stall_D;
  logic             bubble_E;
  logic             flush_all;
  logic             md_busy;
  logic [CNT_W-1:0] md_cnt;
  logic [15:0]      stall_cycles;

  modport master (
    output rs_D, rt_D, use_rs_D, use_rt_D, Tuse_rs_D, Tuse_rt_D,
           RegWrite_E, Dst_E, Tnew_E, RegWrite_M, Dst_M, Tnew_M,
           md_use_D, md_start_E, md_div_E, eret_D, mtc0_epc_E, mtc0_epc_M, Req,
    input  stall_F, stall_D, bubble_E, flush_all, md_busy, md_cnt, stall_cycles
  );

  modport slave (
    input  rs_D, rt_D, use_rs_D, use_rt_D, Tuse_rs_D, Tuse_rt_D,
           RegWrite_E, Dst_E, Tnew_E, RegWrite_M, Dst_M, Tnew_M,
           md_use_D, md_start_E, md_div_E, eret_D, mtc0_epc_E, mtc0_epc_M, Req,
    output stall_F, stall_D, bubble_E, flush_all, md_busy, md_cnt, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage P7 pipeline: GPR Tuse/Tnew interlock,
// MDU busy countdown, eret-vs-mtc0(EPC) interlock and exception flush.
module pipe_hazard_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic [CNT_W-1:0] md_cnt;
  logic [15:0]      stall_cycles;
  logic             md_busy_raw;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall_eret;
  logic             stall;

  // A source stalls only if a producer in E or M will not have its value
  // ready by the time the D instruction needs it; $0 is never a real producer.
  function automatic logic gpr_hazard(
    input logic       use_src,
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic       we_e,
    input logic [4:0] dst_e,
    input logic [1:0] tnew_e,
    input logic       we_m,
    input logic [4:0] dst_m,
    input logic [1:0] tnew_m
  );
    logic hit_e;
    logic hit_m;
    hit_e = we_e && (dst_e == src) && (tnew_e > tuse);
    hit_m = we_m && (dst_m == src) && (tnew_m > tuse);
    return use_src && (src != 5'd0) && (hit_e || hit_m);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stall_rs    = gpr_hazard(hz.use_rs_D, hz.rs_D, hz.Tuse_rs_D,
                             hz.RegWrite_E, hz.Dst_E, hz.Tnew_E,
                             hz.RegWrite_M, hz.Dst_M, hz.Tnew_M);
    stall_rt    = gpr_hazard(hz.use_rt_D, hz.rt_D, hz.Tuse_rt_D,
                             hz.RegWrite_E, hz.Dst_E, hz.Tnew_E,
                             hz.RegWrite_M, hz.Dst_M, hz.Tnew_M);
    md_busy_raw = (md_cnt != '0) || (hz.md_start_E && !hz.Req);
    stall_md    = hz.md_use_D && md_busy_raw;
    stall_eret  = hz.eret_D && (hz.mtc0_epc_E || hz.mtc0_epc_M);
    stall       = (stall_rs || stall_rt || stall_md || stall_eret) && !hz.Req && !reset;
  end

  // Reset looks like a flush to the pipeline registers; Req overrides stalls.
  assign hz.stall_F      = stall;
  assign hz.stall_D      = stall;
  assign hz.bubble_E     = stall || reset;
  assign hz.flush_all    = hz.Req || reset;
  assign hz.md_busy      = md_busy_raw && !reset;
  assign hz.md_cnt       = md_cnt;
  assign hz.stall_cycles = stall_cycles;

  // A same-cycle start is dropped on Req, but an in-flight countdown keeps running.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt       <= '0;
      stall_cycles <= '0;
    end else begin
      if (hz.md_start_E && !hz.Req)
        md_cnt <= hz.md_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;
      if (stall)
        stall_cycles <= sat_inc16(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed checking of pipe_hazard_ctrl against a cycle-level
// reference model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   md_m    = 0;
  int   sc_m    = 0;
  bit   obs_stall;
  int   stall_count;

  pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipe_hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // A D-stage source must wait if any pending producer of it needs more cycles
  // than the consumer can tolerate.
  function automatic bit src_waits(input bit use_src, input int src, input int tuse);
    int wr[2];
    int dst[2];
    int tnew[2];
    bit w;
    wr   = '{int'(hz.RegWrite_E), int'(hz.RegWrite_M)};
    dst  = '{int'(hz.Dst_E), int'(hz.Dst_M)};
    tnew = '{int'(hz.Tnew_E), int'(hz.Tnew_M)};
    w = 0;
    if (!use_src || src == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (wr[k] != 0 && dst[k] == src && tnew[k] > tuse) w = 1;
    return w;
  endfunction

  task automatic idle();
    hz.rs_D = 0; hz.rt_D = 0; hz.use_rs_D = 0; hz.use_rt_D = 0;
    hz.Tuse_rs_D = 0; hz.Tuse_rt_D = 0;
    hz.RegWrite_E = 0; hz.Dst_E = 0; hz.Tnew_E = 0;
    hz.RegWrite_M = 0; hz.Dst_M = 0; hz.Tnew_M = 0;
    hz.md_use_D = 0; hz.md_start_E = 0; hz.md_div_E = 0;
    hz.eret_D = 0; hz.mtc0_epc_E = 0; hz.mtc0_epc_M = 0; hz.Req = 0;
    reset = 0;
  endtask

  // Inputs are set just after a falling edge; check, cross one rising edge, return at the next falling edge.
  task automatic step();
    bit e_stall, e_bub, e_flush, e_busy, want;
    #1;
    if (reset) begin
      e_stall = 0; e_bub = 1; e_flush = 1; e_busy = 0;
    end else begin
      e_busy  = (md_m != 0) || (hz.md_start_E && !hz.Req);
      want    = src_waits(hz.use_rs_D, hz.rs_D, hz.Tuse_rs_D)
             || src_waits(hz.use_rt_D, hz.rt_D, hz.Tuse_rt_D)
             || (hz.md_use_D && e_busy)
             || (hz.eret_D && (hz.mtc0_epc_E || hz.mtc0_epc_M));
      e_stall = want && !hz.Req;
      e_bub   = e_stall;
      e_flush = hz.Req;
    end
    chk("stall_F", hz.stall_F, e_stall);
    chk("stall_D", hz.stall_D, e_stall);
    chk("bubble_E", hz.bubble_E, e_bub);
    chk("flush_all", hz.flush_all, e_flush);
    chk("md_busy", hz.md_busy, e_busy);
    chk("md_cnt", int'(hz.md_cnt), md_m);
    chk("stall_cycles", int'(hz.stall_cycles), sc_m);
    obs_stall = hz.stall_F;
    if (obs_stall) stall_count++;
    @(posedge clk);
    if (reset) begin
      md_m = 0; sc_m = 0;
    end else begin
      if (hz.md_start_E && !hz.Req) md_m = hz.md_div_E ? DIV_LAT : MULT_LAT;
      else if (md_m > 0) md_m--;
      if (e_stall && sc_m < 65535) sc_m++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    step();
    reset = 1;
    step();
    chk("rst_md_cnt", int'(hz.md_cnt), 0);
    chk("rst_stall_cycles", int'(hz.stall_cycles), 0);
    idle();

    // load-use through E then M
    hz.RegWrite_E = 1; hz.Dst_E = 8; hz.Tnew_E = 2;
    hz.rs_D = 8; hz.use_rs_D = 1; hz.Tuse_rs_D = 0;
    step(); chk("loaduse_E", obs_stall, 1);
    hz.RegWrite_E = 0; hz.RegWrite_M = 1; hz.Dst_M = 8; hz.Tnew_M = 1;
    step(); chk("loaduse_M", obs_stall, 1);
    hz.Tnew_M = 0;
    step(); chk("loaduse_rel", obs_stall, 0);
    idle();

    // $0 and forwardable cases
    hz.RegWrite_E = 1; hz.Dst_E = 0; hz.Tnew_E = 2; hz.use_rs_D = 1; hz.rs_D = 0;
    step(); chk("zero_reg", obs_stall, 0);
    idle();
    hz.RegWrite_E = 1; hz.Dst_E = 9; hz.Tnew_E = 1; hz.use_rt_D = 1; hz.rt_D = 9; hz.Tuse_rt_D = 1;
    step(); chk("forwardable", obs_stall, 0);
    idle();

    // MDU: div stalls 11 cycles, mult 6
    for (int d = 1; d >= 0; d--) begin
      stall_count = 0;
      hz.md_use_D = 1; hz.md_start_E = 1; hz.md_div_E = d[0];
      step();
      hz.md_start_E = 0; hz.md_div_E = 0;
      repeat (14) step();
      chk(d ? "div_stall_len" : "mult_stall_len", stall_count, d ? 11 : 6);
      idle();
    end

    // Req precedence
    hz.eret_D = 1; hz.mtc0_epc_E = 1; hz.Req = 1;
    step(); chk("req_no_stall", obs_stall, 0);
    idle();
    hz.md_start_E = 1; hz.md_div_E = 1; hz.Req = 1;
    step(); chk("req_cancel_start", int'(hz.md_cnt), 0);
    idle();
    hz.md_start_E = 1; hz.md_div_E = 1;
    step(); hz.md_start_E = 0;
    repeat (3) step();
    hz.Req = 1; step(); hz.Req = 0;
    chk("req_countdown", int'(hz.md_cnt), 6);
    idle();

    // eret interlock
    hz.eret_D = 1; hz.mtc0_epc_E = 1;
    step(); chk("eret_E", obs_stall, 1);
    hz.mtc0_epc_E = 0; hz.mtc0_epc_M = 1;
    step(); chk("eret_M", obs_stall, 1);
    hz.mtc0_epc_M = 0;
    step(); chk("eret_rel", obs_stall, 0);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hz.rs_D = 5'($urandom_range(0, 3)); hz.rt_D = 5'($urandom_range(0, 3));
      hz.use_rs_D = 1'($urandom); hz.use_rt_D = 1'($urandom);
      hz.Tuse_rs_D = 2'($urandom); hz.Tuse_rt_D = 2'($urandom);
      hz.RegWrite_E = 1'($urandom); hz.Dst_E = 5'($urandom_range(0, 3)); hz.Tnew_E = 2'($urandom);
      hz.RegWrite_M = 1'($urandom); hz.Dst_M = 5'($urandom_range(0, 3)); hz.Tnew_M = 2'($urandom);
      hz.md_use_D = 1'($urandom); hz.md_start_E = ($urandom_range(0, 7) == 0);
      hz.md_div_E = 1'($urandom);
      hz.eret_D = ($urandom_range(0, 3) == 0);
      hz.mtc0_epc_E = ($urandom_range(0, 3) == 0); hz.mtc0_epc_M = ($urandom_range(0, 3) == 0);
      hz.Req = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    idle();

    // saturation then reset mid-countdown
    do_reset();
    hz.eret_D = 1; hz.mtc0_epc_E = 1;
    step();
    repeat (70000) @(negedge clk);
    sc_m = (sc_m + 70000 > 65535) ? 65535 : sc_m + 70000;
    #1 chk("sat_ffff", int'(hz.stall_cycles), 65535);
    @(negedge clk);
    step();
    idle();
    hz.md_start_E = 1; hz.md_div_E = 1;
    step(); hz.md_start_E = 0;
    repeat (6) step();
    chk("cnt_before_rst", int'(hz.md_cnt), 4);
    reset = 1;
    step();
    reset = 0;
    chk("rst_mid_cnt", int'(hz.md_cnt), 0);
    chk("rst_mid_sc", int'(hz.stall_cycles), 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
